// File: rtl/scoreboard_warp.sv
// Per-warp 4-entry scoreboard: hazard detection, entry allocation on issue,
// and entry release on writeback clear or store replay completion.
module scoreboard_warp (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Src1_IB_Scb,
  input  logic [4:0] Src2_IB_Scb,
  input  logic [4:0] Dst_IB_Scb,
  input  logic       Src1_Valid_IB_Scb,
  input  logic       Src2_Valid_IB_Scb,
  input  logic       Dst_Valid_IB_Scb,
  input  logic       RP_Grt_IB_Scb,
  input  logic       Replay_Complete_IB_Scb,
  input  logic [1:0] Replay_Complete_ScbID_IB_Scb,
  input  logic       Clear_Valid_WB_Scb,
  input  logic [1:0] Clear_ScbID_WB_Scb,
  output logic       Full_Scb_IB,
  output logic       Empty_Scb_IB,
  output logic       Dependent_Scb_IB,
  output logic [1:0] ScbID_Scb_IB,
  output logic       Err_Scb
);

  localparam int unsigned NUM_ENTRIES = 4;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned ID_W        = 2;

  logic [NUM_ENTRIES-1:0] v_q,  v_d;
  logic [NUM_ENTRIES-1:0] dv_q, dv_d;
  logic [REG_W-1:0]       d_q [NUM_ENTRIES];
  logic [REG_W-1:0]       d_d [NUM_ENTRIES];
  logic                   err_q, err_d;

  logic                   full_c;
  logic [ID_W-1:0]        free_id_c;
  logic                   dep_c;

  // Status and lowest-free-entry encoder; all zero-latency from state.
  always_comb begin
    full_c    = &v_q;
    free_id_c = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!v_q[i]) free_id_c = ID_W'(i);
    end
  end

  // RAW (either source) and WAW hazards against pending register writers.
  always_comb begin
    dep_c = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (v_q[i] && dv_q[i]) begin
        if ((Src1_Valid_IB_Scb && (Src1_IB_Scb == d_q[i])) ||
            (Src2_Valid_IB_Scb && (Src2_IB_Scb == d_q[i])) ||
            (Dst_Valid_IB_Scb  && (Dst_IB_Scb  == d_q[i])))
          dep_c = 1'b1;
      end
    end
  end

  // Next-state: allocate, writeback clear, replay clear, all in one cycle.
  always_comb begin
    v_d   = v_q;
    dv_d  = dv_q;
    d_d   = d_q;
    err_d = err_q;

    if (RP_Grt_IB_Scb) begin
      if (full_c) begin
        err_d = 1'b1;
      end else begin
        v_d[free_id_c]  = 1'b1;
        dv_d[free_id_c] = Dst_Valid_IB_Scb;
        d_d[free_id_c]  = Dst_IB_Scb;
      end
    end

    if (Clear_Valid_WB_Scb) begin
      if (v_q[Clear_ScbID_WB_Scb]) v_d[Clear_ScbID_WB_Scb] = 1'b0;
      else                         err_d = 1'b1;
    end

    // Level-sensitive from the IB; only a still-valid store entry is freed.
    if (Replay_Complete_IB_Scb && v_q[Replay_Complete_ScbID_IB_Scb] &&
        !dv_q[Replay_Complete_ScbID_IB_Scb])
      v_d[Replay_Complete_ScbID_IB_Scb] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      dv_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) d_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      dv_q  <= dv_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_ENTRIES; i++) d_q[i] <= d_d[i];
    end
  end

  assign Full_Scb_IB      = full_c;
  assign Empty_Scb_IB     = ~|v_q;
  assign Dependent_Scb_IB = dep_c;
  assign ScbID_Scb_IB     = free_id_c;
  assign Err_Scb          = err_q;

endmodule

// File: tb/tb_scoreboard_warp.sv
// Directed bench for scoreboard_warp with hand-computed expectations.
module tb_scoreboard_warp;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] src1, src2, dst;
  logic       src1_v, src2_v, dst_v;
  logic       grt;
  logic       rc;
  logic [1:0] rc_id;
  logic       clr;
  logic [1:0] clr_id;
  logic       full, empty, dep, err;
  logic [1:0] scbid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  scoreboard_warp dut (
    .clk                          (clk),
    .rst                          (rst),
    .Src1_IB_Scb                  (src1),
    .Src2_IB_Scb                  (src2),
    .Dst_IB_Scb                   (dst),
    .Src1_Valid_IB_Scb            (src1_v),
    .Src2_Valid_IB_Scb            (src2_v),
    .Dst_Valid_IB_Scb             (dst_v),
    .RP_Grt_IB_Scb                (grt),
    .Replay_Complete_IB_Scb       (rc),
    .Replay_Complete_ScbID_IB_Scb (rc_id),
    .Clear_Valid_WB_Scb           (clr),
    .Clear_ScbID_WB_Scb           (clr_id),
    .Full_Scb_IB                  (full),
    .Empty_Scb_IB                 (empty),
    .Dependent_Scb_IB             (dep),
    .ScbID_Scb_IB                 (scbid),
    .Err_Scb                      (err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    src1 = '0; src2 = '0; dst = '0;
    src1_v = 0; src2_v = 0; dst_v = 0;
    grt = 0; rc = 0; rc_id = '0; clr = 0; clr_id = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [4:0] d, input logic dv);
    grt = 1; dst = d; dst_v = dv;
    tick();
    grt = 0; dst = '0; dst_v = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset / idle state
    check("rst_full",  8'(full),  8'd0);
    check("rst_empty", 8'(empty), 8'd1);
    check("rst_scbid", 8'(scbid), 8'd0);
    check("rst_dep",   8'(dep),   8'd0);
    check("rst_err",   8'(err),   8'd0);

    // Four grants, Dst=1..4
    for (int i = 0; i < 4; i++) begin
      check($sformatf("alloc_id%0d", i), 8'(scbid), 8'(i));
      grant(5'(i + 1), 1'b1);
    end
    check("fill_full",  8'(full),  8'd1);
    check("fill_empty", 8'(empty), 8'd0);
    check("fill_scbid", 8'(scbid), 8'd0);
    check("fill_err",   8'(err),   8'd0);

    // Fifth grant while full: error, no allocation of Dst=9
    grant(5'd9, 1'b1);
    check("ovf_err",  8'(err),  8'd1);
    check("ovf_full", 8'(full), 8'd1);
    dst = 5'd9; dst_v = 1; #1;
    check("ovf_noalloc", 8'(dep), 8'd0);
    dst = 5'd3; #1;
    check("waw_dst3", 8'(dep), 8'd1);
    idle();

    // Hazard detection against entry0 Dst=5
    do_reset();
    grant(5'd5, 1'b1);
    src1 = 5'd5; src1_v = 1; #1;
    check("raw_src1", 8'(dep), 8'd1);
    src1_v = 0; #1;
    check("src1_unused", 8'(dep), 8'd0);
    dst = 5'd5; dst_v = 1; #1;
    check("waw_dst", 8'(dep), 8'd1);
    dst_v = 0; src2 = 5'd6; src2_v = 1; #1;
    check("src2_nohaz", 8'(dep), 8'd0);
    src2 = 5'd5; #1;
    check("raw_src2", 8'(dep), 8'd1);
    idle();

    // Fill, clear id2, reallocate in the freed cycle
    grant(5'd6, 1'b1);
    grant(5'd7, 1'b1);
    grant(5'd8, 1'b1);
    check("full2", 8'(full), 8'd1);
    clr = 1; clr_id = 2'd2; src1 = 5'd7; src1_v = 1; #1;
    check("nobypass_full", 8'(full), 8'd1);
    check("nobypass_dep",  8'(dep),  8'd1);
    tick();
    idle(); #1;
    check("clr_full",  8'(full),  8'd0);
    check("clr_scbid", 8'(scbid), 8'd2);
    grant(5'd10, 1'b1);
    check("realloc_full", 8'(full), 8'd1);
    check("realloc_err",  8'(err),  8'd0);

    // Store retire via replay complete; load waits for writeback
    do_reset();
    grant(5'd1, 1'b1);
    grant(5'd0, 1'b0);
    rc = 1; rc_id = 2'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("store_scbid_c%0d", c), 8'(scbid), 8'd1);
      check($sformatf("store_err_c%0d", c),   8'(err),   8'd0);
    end
    rc_id = 2'd0;
    for (int c = 0; c < 3; c++) tick();
    rc = 0; src1 = 5'd1; src1_v = 1; #1;
    check("load_held_empty", 8'(empty), 8'd0);
    check("load_held_dep",   8'(dep),   8'd1);
    check("load_held_err",   8'(err),   8'd0);
    src1_v = 0;
    clr = 1; clr_id = 2'd0;
    tick();
    clr = 0; #1;
    check("load_wb_empty", 8'(empty), 8'd1);
    check("load_wb_err",   8'(err),   8'd0);

    // Simultaneous grant + WB clear + replay clear
    grant(5'd3, 1'b1);
    grant(5'd0, 1'b0);
    grt = 1; dst = 5'd4; dst_v = 1;
    clr = 1; clr_id = 2'd0; rc = 1; rc_id = 2'd1;
    tick();
    idle(); #1;
    check("simul_scbid", 8'(scbid), 8'd0);
    check("simul_empty", 8'(empty), 8'd0);
    check("simul_err",   8'(err),   8'd0);
    dst = 5'd4; dst_v = 1; #1;
    check("simul_alloc2", 8'(dep), 8'd1);
    idle();

    // WB clear and replay clear to the same store entry: single free
    grant(5'd0, 1'b0);
    clr = 1; clr_id = 2'd0; rc = 1; rc_id = 2'd0;
    tick();
    idle(); #1;
    check("same_id_scbid", 8'(scbid), 8'd0);
    check("same_id_err",   8'(err),   8'd0);

    // Writeback clear to a free id
    clr = 1; clr_id = 2'd3;
    tick();
    idle(); #1;
    check("clr_free_err", 8'(err), 8'd1);

    // Async reset while full
    grant(5'd11, 1'b1);
    grant(5'd12, 1'b1);
    grant(5'd13, 1'b1);
    check("pre_rst_full", 8'(full), 8'd1);
    rst = 1; #1;
    check("async_empty", 8'(empty), 8'd1);
    check("async_full",  8'(full),  8'd0);
    check("async_err",   8'(err),   8'd0);
    tick();
    rst = 0; #1;

    // Late clear after reset
    clr = 1; clr_id = 2'd1;
    tick();
    idle(); #1;
    check("late_clr_err", 8'(err), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
